// File: rtl/int_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_e;

  localparam logic [9:0]  DEF_VEC_BASE   = 10'h3F0;
  localparam int unsigned DEF_VEC_STRIDE = 4;

  // Full-width vector address; callers truncate to their address width.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [31:0] id);
    return base + id * stride;
  endfunction

endpackage

// File: rtl/int_controller_if.sv
// Request/ack/return handshake between the interrupt controller and the control unit.
// irq_req stays high with irq_id/irq_vec stable until the unit pulses irq_ack (taken)
// or the controller withdraws it; irq_ret is a single-cycle pulse ending the handler.
interface int_controller_if #(
  parameter int ID_W   = 2,
  parameter int ADDR_W = 10
) ();
  logic              irq_req;
  logic [ID_W-1:0]   irq_id;
  logic [ADDR_W-1:0] irq_vec;
  logic              irq_ack;
  logic              irq_ret;
  logic              in_service;

  modport master (
    output irq_req, irq_id, irq_vec, in_service,
    input  irq_ack, irq_ret
  );

  modport slave (
    input  irq_req, irq_id, irq_vec, in_service,
    output irq_ack, irq_ret
  );
endinterface

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over an N-bit request vector.
module int_prio_enc #(
  parameter int N    = 3,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: synchronises request lines, latches them as pending,
// masks and arbitrates them, and runs a non-nested request/service handshake.
module int_controller
  import int_pkg::*;
#(
  parameter int               N_IRQ      = 3,
  parameter int               ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] VEC_BASE  = ADDR_W'(DEF_VEC_BASE),
  parameter int unsigned      VEC_STRIDE = DEF_VEC_STRIDE,
  parameter logic [N_IRQ-1:0] EDGE_MASK  = {N_IRQ{1'b1}},
  parameter int               ID_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic [N_IRQ-1:0] mask_q,
  output logic [N_IRQ-1:0] pending,
  output int_state_e       dbg_state,
  int_controller_if.master cu
);

  logic [N_IRQ-1:0] sync1_q, sync2_q, sync3_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_d;
  logic [N_IRQ-1:0] edge_set;
  logic [N_IRQ-1:0] id_onehot;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] eligible;
  logic             id_masked;

  int_state_e       state_q, state_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic             irq_req_q, irq_req_d;
  logic             in_service_q, in_service_d;

  logic             enc_valid;
  logic [ID_W-1:0]  enc_id;

  assign eligible = pending_q & ~mask_q;

  int_prio_enc #(
    .N    (N_IRQ),
    .ID_W (ID_W)
  ) u_prio_enc (
    .req   (eligible),
    .valid (enc_valid),
    .id    (enc_id)
  );

  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      id_onehot[i] = (irq_id_q == ID_W'(i));
    end
  end

  assign id_masked = |(id_onehot & mask_q);
  assign edge_set  = sync2_q & ~sync3_q;

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    ack_clr  = '0;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          state_d  = ST_REQ;
          irq_id_d = enc_id;
        end
      end
      ST_REQ: begin
        // A taken request beats a withdrawal caused by a late mask write.
        if (cu.irq_ack) begin
          state_d = ST_SERVICE;
          ack_clr = id_onehot & EDGE_MASK;
        end else if (id_masked) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (cu.irq_ret) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    irq_req_d    = (state_d == ST_REQ);
    in_service_d = (state_d == ST_SERVICE);
  end

  // Edge lines: a new edge in the same cycle as the ack clear keeps the line pending.
  assign pending_d = (EDGE_MASK & ((pending_q & ~ack_clr) | edge_set)) |
                     (~EDGE_MASK & sync2_q);

  assign mask_d = mask_we ? mask_wdata : mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      sync3_q      <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      state_q      <= ST_IDLE;
      irq_id_q     <= '0;
      irq_req_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      sync1_q      <= irq_in;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      state_q      <= state_d;
      irq_id_q     <= irq_id_d;
      irq_req_q    <= irq_req_d;
      in_service_q <= in_service_d;
    end
  end

  assign pending       = pending_q;
  assign dbg_state     = state_q;
  assign cu.irq_req    = irq_req_q;
  assign cu.irq_id     = irq_id_q;
  assign cu.in_service = in_service_q;
  assign cu.irq_vec    = ADDR_W'(vec_addr(32'(VEC_BASE), 32'(VEC_STRIDE), 32'(irq_id_q)));

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Parametrised interrupt controller between the external interrupt lines and the control unit; successor to the fixed 3-line interrupt input of the CPU top.
- Synchronises N request lines and latches them as pending, per line edge- or level-triggered.
- Applies a software mask and selects the highest-priority line.
- Presents one vectored request to the control unit with an ack/return handshake. Non-nested: at most one interrupt in service at a time.

Parameters:
N_IRQ, 3, number of interrupt lines (1..16)
ADDR_W, 10, width of the program-memory vector address
VEC_BASE, 10'h3F0, vector address of line 0
VEC_STRIDE, 4, address distance between consecutive vectors
EDGE_MASK, {N_IRQ{1'b1}}, per line: 1 = rising-edge triggered, 0 = level triggered
ID_W, $clog2(N_IRQ) (min 1), width of irq_id

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
irq_in  in  N_IRQ  asynchronous external interrupt lines
mask_we  in  1  write strobe for the mask register
mask_wdata  in  N_IRQ  new mask value; bit = 1 disables that line
mask_q  out  N_IRQ  current mask register
pending  out  N_IRQ  pending register
irq_req  out  1  request to the control unit
irq_id  out  ID_W  index of the requested or in-service line
irq_vec  out  ADDR_W  VEC_BASE + irq_id*VEC_STRIDE, truncated to ADDR_W
irq_ack  in  1  control unit accepts the request and jumps to irq_vec (one-cycle pulse)
irq_ret  in  1  control unit executed return-from-interrupt (one-cycle pulse)
in_service  out  1  an interrupt handler is executing

Behaviour:
- Reset: sync flops = 0, pending = 0, mask_q = all 1s (all lines disabled), state = IDLE, irq_req = 0, irq_id = 0, in_service = 0. irq_vec = VEC_BASE.
- Synchronisation: 2-flop synchroniser per line, then a third flop for edge detection.
- Edge line, pending set: set on the cycle the synchronised value goes 0->1.
- Edge line, pending clear: cleared on irq_ack for that id. If set and clear occur in the same cycle, set wins.
- Level line: pending mirrors the synchronised level; it is never cleared by ack.
- Latency: irq_in high before edge k -> pending visible after edge k+2 -> irq_req high after edge k+3 (IDLE, unmasked).
- Mask: mask_we writes mask_q at the clock edge. Masking never clears pending; it only blocks selection.
- Priority: eligible = pending & ~mask_q. The lowest index wins.
- FSM IDLE: if eligible != 0, latch irq_id = winner, go to REQ.
- FSM REQ: irq_req = 1; irq_id/irq_vec held stable even if a higher-priority line becomes pending.
  - If irq_ack: go to SERVICE; clear pending[irq_id] if it is an edge line.
  - Else if mask_q[irq_id] = 1 (masked after latch): withdraw, irq_req drops, go to IDLE.
  - ack wins over a simultaneous mask write.
- FSM SERVICE: in_service = 1, irq_req = 0; new events still latch into pending. On irq_ret, go to IDLE. Arbitration resumes the next cycle, so back-to-back interrupts cost 1 idle cycle.
- irq_ack outside REQ and irq_ret outside SERVICE are ignored.
- A level line still asserted at irq_ret is re-requested (the handler must clear its source).
- Reset mid-operation (any state) returns everything to reset values in one cycle; pending events are lost.

Decomposition:
- Package int_pkg: state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2), default VEC_BASE/VEC_STRIDE constants, vector-address function.
- One sub-module, int_prio_enc: combinational N_IRQ-bit lowest-index priority encoder with outputs valid and id.
- Synchroniser, pending register, mask register and FSM stay in int_controller.

Test Plan (N_IRQ=3, EDGE_MASK=3'b011, VEC_BASE=0x3F0, VEC_STRIDE=4):
- Reset, then write mask 3'b000; pulse irq_in[1] for 1 cycle -> irq_req=1 exactly 4 edges after the pulse, irq_id=1, irq_vec=0x3F4. Ack -> pending[1]=0, in_service=1. Ret -> IDLE, irq_req stays 0.
- irq_in[1] and irq_in[0] rise together -> id 0 (vec 0x3F0) served first. After ret, id 1 (vec 0x3F4) requested after one idle cycle.
- Mask 3'b001, pulse irq_in[0] -> pending[0]=1, no irq_req. Write mask 3'b000 -> irq_req next-but-one cycle with id 0.
- Level line 2 held high: request id 2, vec 0x3F8; ack -> pending[2] stays 1. Ret with line still high -> re-request id 2. Drop line before ret -> no re-request.
- In REQ for id 1, write mask 3'b010 -> irq_req falls, state IDLE, pending[1] still 1. Repeat with ack in the same cycle as the mask write -> SERVICE entered.
- Pulse irq_in[0] during SERVICE plus spurious ack/ret in wrong states -> no state change; id 0 is requested after ret. Assert reset in REQ -> all outputs reach reset values.
